// File: rtl/butterfly20_inv.sv
// Inverse radix-2 butterfly over 16 complex lanes: undoes the +/-4 pairing and -j twiddle, halves, 2-stage valid/ready pipeline.
// Optional macro BUTTERFLY20_INV_SAT_EN: saturate the 13-bit result and report it on ovf_flag (default: two's-complement wrap).
module butterfly20_inv #(
  parameter int DATA_W = 14
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_real [0:15],
  input  logic signed [DATA_W-1:0] in_imag [0:15],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-2:0] out_real [0:15],
  output logic signed [DATA_W-2:0] out_imag [0:15],
  output logic                     ovf_flag,
  input  logic                     ovf_clr,
  output logic [15:0]              blk_cnt
);

  localparam int SUM_W = DATA_W + 1;
  localparam int OUT_W = DATA_W - 1;
  localparam int LANES = 16;
  localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [SUM_W-1:0] OUT_MIN = ~OUT_MAX;

  function automatic logic signed [SUM_W-1:0] halve(input logic signed [SUM_W-1:0] v);
    return v >>> 1;
  endfunction

`ifdef BUTTERFLY20_INV_SAT_EN
  function automatic logic out_of_range(input logic signed [SUM_W-1:0] h);
    return (h > OUT_MAX) || (h < OUT_MIN);
  endfunction

  function automatic logic signed [OUT_W-1:0] reduce(input logic signed [SUM_W-1:0] h);
    if (h > OUT_MAX)
      return OUT_MAX[OUT_W-1:0];
    else if (h < OUT_MIN)
      return OUT_MIN[OUT_W-1:0];
    else
      return h[OUT_W-1:0];
  endfunction
`else
  function automatic logic signed [OUT_W-1:0] reduce(input logic signed [SUM_W-1:0] h);
    return h[OUT_W-1:0];
  endfunction
`endif

  logic                    vld_p1, vld_p2;
  logic                    ld_p1, ld_p2, acc_p0;
  logic signed [SUM_W-1:0] sr_p0 [LANES];
  logic signed [SUM_W-1:0] si_p0 [LANES];
  logic signed [SUM_W-1:0] sr_p1 [LANES];
  logic signed [SUM_W-1:0] si_p1 [LANES];
  logic signed [SUM_W-1:0] s_r, s_i, d_r, d_i;

  assign ld_p2     = !vld_p2 || out_ready;
  assign ld_p1     = !vld_p1 || ld_p2;
  assign in_ready  = !vld_p1 || (!out_valid || out_ready);
  assign acc_p0    = in_valid && in_ready;
  assign out_valid = vld_p2;

  // Stage 0: +j twiddle on lanes 2,3 (and 10,11) partners, then 15-bit sum/difference
  always_comb begin
    s_r = '0;
    s_i = '0;
    d_r = '0;
    d_i = '0;
    for (int k = 0; k < LANES; k++) begin
      sr_p0[k] = '0;
      si_p0[k] = '0;
    end
    for (int g = 0; g < LANES; g += 8) begin
      for (int i = 0; i < 4; i++) begin
        s_r = SUM_W'(in_real[g+i]);
        s_i = SUM_W'(in_imag[g+i]);
        if (i >= 2) begin
          d_r = -SUM_W'(in_imag[g+i+4]);
          d_i = SUM_W'(in_real[g+i+4]);
        end else begin
          d_r = SUM_W'(in_real[g+i+4]);
          d_i = SUM_W'(in_imag[g+i+4]);
        end
        sr_p0[g+i]   = s_r + d_r;
        si_p0[g+i]   = s_i + d_i;
        sr_p0[g+i+4] = s_r - d_r;
        si_p0[g+i+4] = s_i - d_i;
      end
    end
  end

  // Stage 1: sum/difference register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      vld_p1 <= 1'b0;
    else if (ld_p1)
      vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (acc_p0) begin
      for (int k = 0; k < LANES; k++) begin
        sr_p1[k] <= sr_p0[k];
        si_p1[k] <= si_p0[k];
      end
    end
  end

  // Stage 2: halved, width-reduced output register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p2 <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        out_real[k] <= '0;
        out_imag[k] <= '0;
      end
    end else if (ld_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        for (int k = 0; k < LANES; k++) begin
          out_real[k] <= reduce(halve(sr_p1[k]));
          out_imag[k] <= reduce(halve(si_p1[k]));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      blk_cnt <= '0;
    else if (out_valid && out_ready)
      blk_cnt <= blk_cnt + 16'd1;
  end

`ifdef BUTTERFLY20_INV_SAT_EN
  logic ovf_evt;

  always_comb begin
    ovf_evt = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (out_of_range(halve(sr_p1[k])) || out_of_range(halve(si_p1[k])))
        ovf_evt = 1'b1;
    end
    ovf_evt = ovf_evt && vld_p1 && ld_p2;
  end

  // Clear wins over a coincident overflow so software never loses a clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      ovf_flag <= 1'b0;
    else if (ovf_clr)
      ovf_flag <= 1'b0;
    else if (ovf_evt)
      ovf_flag <= 1'b1;
  end
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = ovf_clr;
  assign ovf_flag       = 1'b0;
`endif

endmodule

// File: tb/tb_butterfly20_inv.sv
// Self-checking bench for butterfly20_inv: directed cases plus randomized streaming against a lane-level arithmetic model.
module tb_butterfly20_inv;

  logic               clk = 1'b0;
  logic               rstn, in_valid, in_ready, out_valid, out_ready, ovf_flag, ovf_clr;
  logic signed [13:0] in_real [0:15];
  logic signed [13:0] in_imag [0:15];
  logic signed [12:0] out_real [0:15];
  logic signed [12:0] out_imag [0:15];
  logic [15:0]        blk_cnt;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  int q[$];

  always #5 clk = ~clk;

  butterfly20_inv dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag), .ovf_flag(ovf_flag), .ovf_clr(ovf_clr),
    .blk_cnt(blk_cnt)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int half(input int x);
    return (x >= 0) ? x / 2 : -((1 - x) / 2);
  endfunction

  function automatic int fit(input int x);
    int m;
`ifdef BUTTERFLY20_INV_SAT_EN
    m = x;
    if (x > 4095) m = 4095;
    if (x < -4096) m = -4096;
`else
    m = x & 8191;
    if (m >= 4096) m = m - 8192;
`endif
    return m;
  endfunction

  task automatic push_model();
    int er[16];
    int ei[16];
    int sr, si, dr, di, t;
    for (int g = 0; g < 16; g += 8) begin
      for (int i = 0; i < 4; i++) begin
        sr = in_real[g+i];
        si = in_imag[g+i];
        dr = in_real[g+i+4];
        di = in_imag[g+i+4];
        if (i >= 2) begin
          t  = dr;
          dr = -di;
          di = t;
        end
        er[g+i]   = fit(half(sr + dr));
        er[g+i+4] = fit(half(sr - dr));
        ei[g+i]   = fit(half(si + di));
        ei[g+i+4] = fit(half(si - di));
      end
    end
    for (int k = 0; k < 16; k++) q.push_back(er[k]);
    for (int k = 0; k < 16; k++) q.push_back(ei[k]);
  endtask

  task automatic zero_in();
    for (int k = 0; k < 16; k++) begin
      in_real[k] = '0;
      in_imag[k] = '0;
    end
  endtask

  function automatic logic signed [13:0] rnd14();
    case ($urandom_range(0, 3))
      0:       return {1'b1, 13'd0};
      1:       return {1'b0, {13{1'b1}}};
      default: return 14'($urandom);
    endcase
  endfunction

  task automatic rand_in();
    for (int k = 0; k < 16; k++) begin
      in_real[k] = rnd14();
      in_imag[k] = rnd14();
    end
  endtask

  // One clock: drive controls, sample mid-cycle, score handshakes, end at posedge+1
  task automatic step(input logic iv, input logic orr);
    in_valid  = iv;
    out_ready = orr;
    #3;
    if (in_valid && in_ready) push_model();
    if (out_valid) begin
      total++;
      assert (q.size() >= 32) else begin
        bad++;
        $error("FAIL sb_empty observed=%0d expected=32", q.size());
      end
      if (q.size() >= 32) begin
        for (int k = 0; k < 16; k++) begin
          check(orr ? "emit_re" : "hold_re", out_real[k], q[k]);
          check(orr ? "emit_im" : "hold_im", out_imag[k], q[16+k]);
        end
        if (orr) begin
          repeat (32) void'(q.pop_front());
          exp_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Single block into an empty pipe; returns with the block on the outputs
  task automatic run1();
    step(1'b1, 1'b1);
    zero_in();
    check("lat1_valid", out_valid, 0);
    step(1'b0, 1'b1);
    check("lat2_valid", out_valid, 1);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rstn = 1'b0;
    q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_cnt", blk_cnt, 0);
    rstn = 1'b1;
    check("rel_in_ready", in_ready, 1);
  endtask

  initial begin
    rstn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    ovf_clr = 1'b0;
    zero_in();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_blk_cnt", blk_cnt, 0);
    check("rst_ovf", ovf_flag, 0);
    check("rst_out_re0", out_real[0], 0);
    check("rst_out_im15", out_imag[15], 0);
    rstn = 1'b1;
    check("rel_in_ready", in_ready, 1);

    // straight lane
    in_real[0] = 14'sd300;
    in_real[4] = 14'sd100;
    run1();
    check("straight_re0", out_real[0], 200);
    check("straight_re4", out_real[4], 100);
    check("straight_re1", out_real[1], 0);
    check("straight_im0", out_imag[0], 0);
    step(1'b0, 1'b1);

    // twiddle lane
    in_real[2] = 14'sd10;
    in_imag[6] = -14'sd4;
    run1();
    check("twid_re2", out_real[2], 7);
    check("twid_re6", out_real[6], 3);
    check("twid_im2", out_imag[2], 0);
    check("twid_im6", out_imag[6], 0);
    step(1'b0, 1'b1);

    // floor rounding
    in_real[0] = 14'sd3;
    run1();
    check("rnd_pos_re0", out_real[0], 1);
    check("rnd_pos_re4", out_real[4], 1);
    step(1'b0, 1'b1);
    in_real[0] = -14'sd3;
    run1();
    check("rnd_neg_re0", out_real[0], -2);
    check("rnd_neg_re4", out_real[4], -2);
    step(1'b0, 1'b1);

    // overflow
    in_real[0] = 14'sd8000;
    in_real[4] = 14'sd8000;
    run1();
`ifdef BUTTERFLY20_INV_SAT_EN
    check("ovf_re0", out_real[0], 4095);
`else
    check("ovf_re0", out_real[0], -192);
`endif
    check("ovf_re4", out_real[4], 0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
`ifdef BUTTERFLY20_INV_SAT_EN
    check("ovf_sticky", ovf_flag, 1);
`else
    check("ovf_sticky", ovf_flag, 0);
`endif
    ovf_clr = 1'b1;
    step(1'b0, 1'b1);
    ovf_clr = 1'b0;
    check("ovf_cleared", ovf_flag, 0);
    ovf_clr = 1'b1;
    in_real[0] = 14'sd8000;
    in_real[4] = 14'sd8000;
    run1();
    check("ovf_clr_prio", ovf_flag, 0);
    step(1'b0, 1'b1);
    ovf_clr = 1'b0;
    in_real[0] = 14'sd8000;
    in_real[4] = 14'sd8000;
    run1();
`ifdef BUTTERFLY20_INV_SAT_EN
    check("ovf_reset_again", ovf_flag, 1);
`else
    check("ovf_reset_again", ovf_flag, 0);
`endif
    step(1'b0, 1'b1);
    check("cnt_directed", blk_cnt, exp_cnt);

    for (int n = 0; n < 8; n++) begin
      rand_in();
      run1();
      step(1'b0, 1'b1);
    end
    check("cnt_singles", blk_cnt, exp_cnt);

    // backpressure: third block must stall
    do_reset();
    rand_in();
    step(1'b1, 1'b0);
    rand_in();
    step(1'b1, 1'b0);
    rand_in();
    step(1'b1, 1'b0);
    check("bp_in_ready", in_ready, 0);
    step(1'b1, 1'b0);
    check("bp_held", q.size(), 64);
    check("bp_out_valid", out_valid, 1);
    step(1'b1, 1'b1);
    zero_in();
    repeat (3) step(1'b0, 1'b1);
    check("bp_blk_cnt", blk_cnt, 3);
    check("bp_drained", q.size(), 0);
    check("bp_idle", out_valid, 0);

    // reset with two blocks in flight
    rand_in();
    step(1'b1, 1'b0);
    rand_in();
    step(1'b1, 1'b0);
    in_valid = 1'b0;
    rstn = 1'b0;
    #2;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_cnt", blk_cnt, 0);
    q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    check("mid_rel_in_ready", in_ready, 1);
    step(1'b0, 1'b1);
    check("mid_no_ghost1", out_valid, 0);
    step(1'b0, 1'b1);
    check("mid_no_ghost2", out_valid, 0);
    check("mid_cnt", blk_cnt, 0);
    rand_in();
    run1();
    step(1'b0, 1'b1);
    check("mid_cnt_after", blk_cnt, 1);

    // random streaming with random backpressure
    for (int n = 0; n < 300; n++) begin
      rand_in();
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end
    repeat (4) step(1'b0, 1'b1);
    check("stream_drained", q.size(), 0);
    check("stream_cnt", blk_cnt, exp_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
